md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Pipeline-side initiator for the multiply/divide unit, placed in the E stage between the decoded instruction and the MD block. It turns mult/multu/div/divu and mthi/mtlo instructions into MD start/override pulses and tracks the MD latency with its own shadow counter. From that counter it derives the D-stage stall for any instruction that touches HI/LO, and it cross-checks the MD `busy` output against the counter, latching a sticky protocol error on any mismatch.

## Interface
- `MUL_LAT`, default 5: cycles `md_busy` stays high after a multiply start.
- `DIV_LAT`, default 10: cycles `md_busy` stays high after a divide start.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `d_md_use`  in  1  the D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- `e_valid`  in  1  the E-stage slot holds a real instruction (0 = bubble).
- `e_md_start_req`  in  1  the E instruction is mult/multu/div/divu.
- `e_md_op`  in  1  1 = multiply, 0 = divide.
- `e_md_signed`  in  1  signed operation.
- `e_mt_req`  in  1  the E instruction is mthi/mtlo.
- `e_mt_dest`  in  1  1 = HI, 0 = LO.
- `e_rs_val`, `e_rt_val`  in  32  forwarded operands.
- `flush`  in  1  exception/eret; kills the E instruction this cycle.
- `md_busy`  in  1  busy output from the MD unit.
- `md_start`, `md_op`, `md_signed`, `md_ovrd`, `md_ovrd_dest`  out  1  drive the MD unit.
- `md_d1`, `md_d2`  out  32  MD operands.
- `stall_d`  out  1  hold D and insert a bubble into E.
- `proto_err`  out  1  sticky protocol error.

## Operation
- FSM has two states:
  - IDLE: no MD operation in flight.
  - BUSY: an operation is in flight; `cnt` (4 bits) holds the remaining busy cycles.
- `kill = flush | ~e_valid`.
- `md_start = e_md_start_req & ~kill & (state==IDLE)`. The output is combinational.
- `md_ovrd = e_mt_req & ~kill & (state==IDLE)` and `md_ovrd_dest = e_mt_dest`.
- `md_op`, `md_signed`, `md_d1 = e_rs_val` and `md_d2 = e_rt_val` are pass-throughs.
- IDLE→BUSY on `md_start`: load `cnt = e_md_op ? MUL_LAT : DIV_LAT`.
- In BUSY, `cnt` decrements every cycle. When `cnt==1`, the next state is IDLE with `cnt = 0`.
- `flush` during BUSY has no effect. The MD operation cannot be cancelled and runs to completion.
- `stall_d = d_md_use & (md_start | state==BUSY)`.
- `proto_err` is set, and stays set until reset, on any of these:
  - `md_busy != (state==BUSY)`, checked on every cycle.
  - `(e_md_start_req | e_mt_req) & ~kill` while in BUSY. The request is suppressed (no start, no override).
  - `e_md_start_req & e_mt_req` in the same cycle.

## Timing
- Reset (`rst_n` low at an edge) forces:
  - state IDLE, `cnt = 0`, `proto_err = 0`;
  - consequently `stall_d = 0`, and `md_start`/`md_ovrd` are 0 unless the E inputs request them.
- Multiply issued in cycle T (`md_start` = 1 in T):
  - `md_busy` and the BUSY state both cover cycles T+1..T+5;
  - IDLE again at T+6, when HI/LO hold the result.
- A divide follows the same pattern with busy over T+1..T+10.
- `stall_d` is high in T and in every BUSY cycle while `d_md_use` = 1. An mfhi held in D therefore enters E no earlier than T+7 for a multiply.
- mthi/mtlo: `md_ovrd` is a single-cycle pulse, no state change, and no stall.
- Back-to-back: a new MD instruction can start in the first IDLE cycle (T+6 for a multiply).
- `rst_n` low mid-operation forces IDLE at that edge. The MD unit is reset by the same signal.

## Test plan
- mult, signed, rs=-3, rt=7, mfhi behind it in D:
  - `md_start` pulses in T, `stall_d` is high T..T+5;
  - HI=0xFFFFFFFF and LO=0xFFFFFFEB at T+6;
  - `proto_err` = 0.
- divu, rs=100, rt=7: BUSY is 10 cycles, then LO=14 and HI=2. `d_md_use` = 0 throughout gives `stall_d` = 0.
- mult in E with `flush` = 1: `md_start` = 0, state stays IDLE, `stall_d` = 0. Repeat with `e_valid` = 0 and expect the same.
- mtlo in E with rs=0x1234: `md_ovrd` = 1 for one cycle with `md_ovrd_dest` = 0 and `md_d1` = 0x1234; no stall.
- Inject `md_busy` low at T+3 of a multiply: `proto_err` goes 1 at the next edge and holds until `rst_n` is pulsed low.
- Assert `rst_n` low at T+2 of a divide: state is IDLE and `stall_d` is 0 the next cycle; a new mult starts cleanly with no `proto_err`.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: generates MD start/override
// pulses, shadows MD latency to drive the D-stage stall, and flags busy/protocol mismatches.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_md_use,
  input  logic        e_valid,
  input  logic        e_md_start_req,
  input  logic        e_md_op,
  input  logic        e_md_signed,
  input  logic        e_mt_req,
  input  logic        e_mt_dest,
  input  logic [31:0] e_rs_val,
  input  logic [31:0] e_rt_val,
  input  logic        flush,
  input  logic        md_busy,
  output logic        md_start,
  output logic        md_op,
  output logic        md_signed,
  output logic        md_ovrd,
  output logic        md_ovrd_dest,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  output logic        stall_d,
  output logic        proto_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       kill, in_busy, err_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      proto_err <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (err_now)
        proto_err <= 1'b1;
    end
  end

  // A started operation always runs to completion; flush cannot shorten BUSY.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (md_start) begin
          next_state = BUSY;
          next_cnt   = e_md_op ? MUL_CNT : DIV_CNT;
        end
      end
      BUSY: begin
        if (cnt <= 4'd1) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    kill     = flush | ~e_valid;
    in_busy  = (state == BUSY);
    md_start = e_md_start_req & ~kill & ~in_busy;
    md_ovrd  = e_mt_req & ~kill & ~in_busy;
    stall_d  = d_md_use & (md_start | in_busy);
    // Shadow counter and MD busy must agree; requests arriving while busy are dropped and flagged.
    err_now  = (md_busy != in_busy)
             | ((e_md_start_req | e_mt_req) & ~kill & in_busy)
             | (e_md_start_req & e_mt_req);
  end

  assign md_ovrd_dest = e_mt_dest;
  assign md_op        = e_md_op;
  assign md_signed    = e_md_signed;
  assign md_d1        = e_rs_val;
  assign md_d2        = e_rt_val;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a small MD-unit stub that produces md_busy and HI/LO.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, d_md_use, e_valid, e_md_start_req, e_md_op, e_md_signed;
  logic        e_mt_req, e_mt_dest, flush, md_busy, inject_low;
  logic [31:0] e_rs_val, e_rt_val;
  logic        md_start, md_op, md_signed, md_ovrd, md_ovrd_dest, stall_d, proto_err;
  logic [31:0] md_d1, md_d2;

  logic [3:0]  stub_cnt;
  logic [31:0] hi, lo, pend_hi, pend_lo;
  int          checks = 0;
  int          passes = 0;

  md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .rst_n(rst_n), .d_md_use(d_md_use), .e_valid(e_valid),
    .e_md_start_req(e_md_start_req), .e_md_op(e_md_op), .e_md_signed(e_md_signed),
    .e_mt_req(e_mt_req), .e_mt_dest(e_mt_dest), .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
    .flush(flush), .md_busy(md_busy), .md_start(md_start), .md_op(md_op),
    .md_signed(md_signed), .md_ovrd(md_ovrd), .md_ovrd_dest(md_ovrd_dest),
    .md_d1(md_d1), .md_d2(md_d2), .stall_d(stall_d), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] md_calc(input logic op, input logic sgn,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb;
    if (op) begin
      ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb;
    end
    if (b == 32'd0)
      return 64'd0;
    if (sgn)
      return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  // MD unit stand-in: busy for the fixed latency, HI/LO committed on the last busy edge.
  assign md_busy = (stub_cnt != 4'd0) && !inject_low;

  always @(posedge clk) begin
    if (!rst_n) begin
      stub_cnt <= 4'd0;
    end else begin
      if (md_start) begin
        stub_cnt <= md_op ? 4'd5 : 4'd10;
        {pend_hi, pend_lo} <= md_calc(md_op, md_signed, md_d1, md_d2);
      end else if (stub_cnt != 4'd0) begin
        stub_cnt <= stub_cnt - 4'd1;
        if (stub_cnt == 4'd1) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
      if (md_ovrd) begin
        if (md_ovrd_dest) hi <= md_d1;
        else              lo <= md_d1;
      end
    end
  end

  task automatic applyStimulus(input logic rst, input logic inj, input logic dmu, input logic ev,
                               input logic sreq, input logic op, input logic sgn, input logic mt,
                               input logic dest, input logic fl,
                               input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    rst_n = rst; inject_low = inj; d_md_use = dmu; e_valid = ev;
    e_md_start_req = sreq; e_md_op = op; e_md_signed = sgn;
    e_mt_req = mt; e_mt_dest = dest; flush = fl; e_rs_val = rs; e_rt_val = rt;
    #1;
  endtask

  task automatic bubble(input logic rst, input logic inj, input logic dmu);
    applyStimulus(rst, inj, dmu, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; inject_low = 1'b0; d_md_use = 1'b0; e_valid = 1'b0; e_md_start_req = 1'b0;
    e_md_op = 1'b0; e_md_signed = 1'b0; e_mt_req = 1'b0; e_mt_dest = 1'b0; flush = 1'b0;
    e_rs_val = 32'd0; e_rt_val = 32'd0;

    bubble(1'b0, 1'b0, 1'b0);
    bubble(1'b0, 1'b0, 1'b1);
    checkOutput("rst_stall", {31'd0, stall_d}, 32'd0);
    checkOutput("rst_err", {31'd0, proto_err}, 32'd0);
    checkOutput("rst_start", {31'd0, md_start}, 32'd0);

    // signed mult -3*7 with an mfhi waiting in D
    applyStimulus(1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 32'hFFFFFFFD, 32'd7);
    checkOutput("mult_start", {31'd0, md_start}, 32'd1);
    checkOutput("mult_stall_t", {31'd0, stall_d}, 32'd1);
    checkOutput("mult_d1", md_d1, 32'hFFFFFFFD);
    checkOutput("mult_d2", md_d2, 32'd7);
    checkOutput("mult_sgn", {31'd0, md_signed}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      bubble(1, 0, 1);
      checkOutput($sformatf("mult_stall_t%0d", i), {31'd0, stall_d}, 32'd1);
      checkOutput($sformatf("mult_nostart_t%0d", i), {31'd0, md_start}, 32'd0);
    end

    // back-to-back divu 100/7 in the first idle cycle, nothing in D
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 32'd100, 32'd7);
    checkOutput("mult_hi", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo", lo, 32'hFFFFFFEB);
    checkOutput("mult_err", {31'd0, proto_err}, 32'd0);
    checkOutput("divu_start", {31'd0, md_start}, 32'd1);
    checkOutput("divu_stall_t", {31'd0, stall_d}, 32'd0);
    checkOutput("divu_op", {31'd0, md_op}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      bubble(1, 0, 0);
      checkOutput($sformatf("divu_stall_t%0d", i), {31'd0, stall_d}, 32'd0);
    end
    bubble(1, 0, 1);
    checkOutput("divu_done_stall", {31'd0, stall_d}, 32'd0);
    checkOutput("divu_lo", lo, 32'd14);
    checkOutput("divu_hi", hi, 32'd2);
    checkOutput("divu_err", {31'd0, proto_err}, 32'd0);

    // killed mult: flush, then bubble slot
    applyStimulus(1, 0, 1, 1, 1, 1, 1, 0, 0, 1, 32'd5, 32'd6);
    checkOutput("flush_start", {31'd0, md_start}, 32'd0);
    checkOutput("flush_stall", {31'd0, stall_d}, 32'd0);
    bubble(1, 0, 1);
    checkOutput("flush_idle", {31'd0, stall_d}, 32'd0);
    applyStimulus(1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 32'd5, 32'd6);
    checkOutput("inval_start", {31'd0, md_start}, 32'd0);
    checkOutput("inval_stall", {31'd0, stall_d}, 32'd0);
    bubble(1, 0, 1);
    checkOutput("inval_idle", {31'd0, stall_d}, 32'd0);
    checkOutput("kill_err", {31'd0, proto_err}, 32'd0);

    // mtlo 0x1234
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 32'h1234, 32'd0);
    checkOutput("mtlo_ovrd", {31'd0, md_ovrd}, 32'd1);
    checkOutput("mtlo_dest", {31'd0, md_ovrd_dest}, 32'd0);
    checkOutput("mtlo_d1", md_d1, 32'h1234);
    checkOutput("mtlo_stall", {31'd0, stall_d}, 32'd0);
    bubble(1, 0, 1);
    checkOutput("mtlo_pulse_end", {31'd0, md_ovrd}, 32'd0);
    checkOutput("mtlo_nostall", {31'd0, stall_d}, 32'd0);
    checkOutput("mtlo_lo", lo, 32'h1234);
    checkOutput("mtlo_hi", hi, 32'd2);

    // md_busy dropped at T+3 of an unsigned mult 6*7
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 32'd6, 32'd7);
    checkOutput("inj_start", {31'd0, md_start}, 32'd1);
    bubble(1, 0, 1);
    bubble(1, 0, 1);
    bubble(1, 1, 1);
    checkOutput("inj_err_before", {31'd0, proto_err}, 32'd0);
    bubble(1, 0, 1);
    checkOutput("inj_err_set", {31'd0, proto_err}, 32'd1);
    bubble(1, 0, 1);
    bubble(1, 0, 1);
    checkOutput("inj_err_sticky", {31'd0, proto_err}, 32'd1);
    checkOutput("inj_lo", lo, 32'd42);
    bubble(0, 0, 0);
    bubble(1, 0, 0);
    checkOutput("inj_err_clear", {31'd0, proto_err}, 32'd0);

    // valid request while busy is suppressed and flagged
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 32'd6, 32'd7);
    bubble(1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 32'd9, 32'd9);
    checkOutput("busyreq_start", {31'd0, md_start}, 32'd0);
    checkOutput("busyreq_err_before", {31'd0, proto_err}, 32'd0);
    bubble(1, 0, 0);
    checkOutput("busyreq_err", {31'd0, proto_err}, 32'd1);
    bubble(1, 0, 0);
    bubble(1, 0, 0);
    bubble(1, 0, 0);
    checkOutput("busyreq_lo", lo, 32'd42);
    bubble(0, 0, 1);

    // reset in the middle of a divide
    applyStimulus(1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 32'd50, 32'd5);
    checkOutput("rdiv_start", {31'd0, md_start}, 32'd1);
    checkOutput("rdiv_err_clr", {31'd0, proto_err}, 32'd0);
    bubble(1, 0, 1);
    checkOutput("rdiv_stall_t1", {31'd0, stall_d}, 32'd1);
    bubble(0, 0, 1);
    bubble(1, 0, 1);
    checkOutput("rdiv_stall_after", {31'd0, stall_d}, 32'd0);
    checkOutput("rdiv_err", {31'd0, proto_err}, 32'd0);
    applyStimulus(1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 32'd3, 32'd5);
    checkOutput("rmul_start", {31'd0, md_start}, 32'd1);
    for (int i = 1; i <= 5; i++) bubble(1, 0, 1);
    checkOutput("rmul_stall_t5", {31'd0, stall_d}, 32'd1);
    bubble(1, 0, 1);
    checkOutput("rmul_done", {31'd0, stall_d}, 32'd0);
    checkOutput("rmul_lo", lo, 32'd15);
    checkOutput("rmul_hi", hi, 32'd0);
    checkOutput("rmul_err", {31'd0, proto_err}, 32'd0);

    // start and move requested together
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 32'd1, 32'd1);
    bubble(1, 0, 0);
    checkOutput("dualreq_err", {31'd0, proto_err}, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
